// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter owner for the five-stage pipeline.
// Chooses the next PC between sequential PC+4, the EX branch target and the
// ID jump target, keeps a hold-until-ack request to instruction memory and
// issues the IF/ID and ID/EX squashes whenever the fetch stream is redirected.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jmp,
    input  logic [31:0]      jmp_target,
    input  logic             if_ack,
    output logic             if_req,
    output logic [31:0]      if_addr,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             if_valid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               redirect;
    logic               validRaw;
    logic [31:0]        brTgt;
    logic [31:0]        jmpTgt;
    logic [31:0]        target;
    logic [31:0]        pcInc;

    // Targets are always word aligned; the low two bits are dropped on load.
    assign brTgt  = {br_target[31:2], 2'b00};
    assign jmpTgt = {jmp_target[31:2], 2'b00};
    assign target = br_taken ? brTgt : jmpTgt;
    assign pcInc  = pc_q + 32'd4;

    // Next-state, redirect selection and fetch handshake for each state.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        if_req   = 1'b0;
        validRaw = 1'b0;
        redirect = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if_req   = 1'b1;
                redirect = br_taken | (jmp & ~stall);
                if (redirect) begin
                    if (if_ack) begin
                        pc_d = target;
                    end else begin
                        pend_d  = target;
                        state_d = DRAIN;
                    end
                end else if (if_ack && !stall) begin
                    pc_d     = pcInc;
                    validRaw = 1'b1;
                end
            end
            DRAIN: begin
                if_req   = 1'b1;
                redirect = br_taken;
                if (br_taken) begin
                    pend_d = brTgt;
                end
                if (if_ack) begin
                    pc_d    = br_taken ? brTgt : pend_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Pulse-style outputs are silenced while reset is held so a stray ack or
    // branch during reset never reaches the pipeline registers.
    assign if_valid     = validRaw & ~rst;
    assign flush_ifid   = redirect & ~rst;
    assign flush_idex   = br_taken & (state_q != BOOT) & ~rst;
    assign if_addr      = pc_q;
    assign pc           = pc_q;
    assign pc_plus4     = pcInc;
    assign redirect_cnt = cnt_q;

    // State, PC, pending target and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= 32'h0000_0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a
// behavioural model of the fetch sequencing rules.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int          CNT_W  = 16;
    localparam longint      MAXCNT = (64'd1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              br_taken;
    logic [31:0]       br_target;
    logic              jmp;
    logic [31:0]       jmp_target;
    logic              if_ack;
    logic              if_req;
    logic [31:0]       if_addr;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic              if_valid;
    logic              flush_ifid;
    logic              flush_idex;
    logic [CNT_W-1:0]  redirect_cnt;

    int testCount = 0;
    int failCount = 0;

    // Behavioural model: booting/draining flags, pc, pending target, count.
    bit          mBoot  = 1'b1;
    bit          mDrain = 1'b0;
    logic [31:0] mPc    = RST_PC;
    logic [31:0] mPend  = 32'h0;
    longint      mCnt   = 0;

    pc_sequencer #(
        .RESET_PC (RST_PC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jmp          (jmp),
        .jmp_target   (jmp_target),
        .if_ack       (if_ack),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .if_valid     (if_valid),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .redirect_cnt (redirect_cnt)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit modelRedirect();
        return !rst && !mBoot && (br_taken || (!mDrain && jmp && !stall));
    endfunction

    function automatic logic [31:0] modelTarget();
        logic [31:0] t;
        t = br_taken ? br_target : jmp_target;
        return t & 32'hFFFF_FFFC;
    endfunction

    // Compare every output against what the model says for this cycle.
    task automatic checkOutput();
        bit          rd;
        logic [31:0] expCnt;
        rd     = modelRedirect();
        expCnt = (mCnt >= MAXCNT) ? 32'(MAXCNT) : 32'(mCnt);
        checkVal("if_req",     32'(if_req),       32'(!mBoot));
        checkVal("if_addr",    if_addr,           mPc);
        checkVal("pc",         pc,                mPc);
        checkVal("pc_plus4",   pc_plus4,          mPc + 32'd4);
        checkVal("if_valid",   32'(if_valid),
                 32'(!rst && !mBoot && !mDrain && !rd && if_ack && !stall));
        checkVal("flush_ifid", 32'(flush_ifid),   32'(rd));
        checkVal("flush_idex", 32'(flush_idex),   32'(!rst && !mBoot && br_taken));
        checkVal("redirect_cnt", 32'(redirect_cnt), expCnt);
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic modelUpdate();
        bit          rd;
        logic [31:0] tg;
        rd = modelRedirect();
        tg = modelTarget();
        if (rst) begin
            mBoot = 1'b1; mDrain = 1'b0; mPc = RST_PC; mPend = 32'h0; mCnt = 0;
        end else if (mBoot) begin
            mBoot = 1'b0;
        end else if (mDrain) begin
            if (br_taken) begin
                mPend = tg;
                mCnt++;
            end
            if (if_ack) begin
                mPc    = mPend;
                mDrain = 1'b0;
            end
        end else if (rd) begin
            mCnt++;
            if (if_ack) mPc = tg;
            else begin
                mPend  = tg;
                mDrain = 1'b1;
            end
        end else if (if_ack && !stall) begin
            mPc = mPc + 32'd4;
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, check, then clock.
    task automatic applyStimulus(input logic r, input logic s, input logic b,
                                 input logic [31:0] bt, input logic j,
                                 input logic [31:0] jt, input logic a,
                                 input bit doCheck = 1'b1);
        @(negedge clk);
        rst = r; stall = s; br_taken = b; br_target = bt;
        jmp = j; jmp_target = jt; if_ack = a;
        #1;
        if (doCheck) checkOutput();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        jmp = 1'b0; jmp_target = 32'h0; if_ack = 1'b1;

        // Reset then boot, then three zero-wait fetches.
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkVal("reset_pc", pc, 32'h3000);
        checkVal("reset_cnt", 32'(redirect_cnt), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkVal("first_addr", if_addr, 32'h3000);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkVal("second_addr", if_addr, 32'h3004);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkVal("third_addr", if_addr, 32'h3008);

        // Stall with a jump present: held PC, jump ignored.
        applyStimulus(0, 1, 0, 0, 1, 32'h3200, 1);
        applyStimulus(0, 1, 0, 0, 1, 32'h3200, 1);
        checkVal("stall_hold", pc, 32'h3008);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkVal("after_stall", pc, 32'h300C);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);

        // Branch and jump together: branch wins.
        applyStimulus(0, 0, 1, 32'h3100, 1, 32'h3200, 1);
        checkVal("branch_prio", if_addr, 32'h3100);
        checkVal("branch_cnt", 32'(redirect_cnt), 32'h1);

        // Three wait states, jump in the first one.
        applyStimulus(0, 0, 0, 0, 1, 32'h4000, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkVal("drain_stable", if_addr, 32'h3100);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkVal("drain_done", if_addr, 32'h4000);

        // Branch overwrites the pending jump while draining.
        applyStimulus(0, 0, 0, 0, 1, 32'h4000, 0);
        applyStimulus(0, 0, 1, 32'h5002, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkVal("overwrite", if_addr, 32'h5000);

        // Reset in the middle of a drain.
        applyStimulus(0, 0, 0, 0, 1, 32'h6000, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkVal("mid_drain_rst_pc", pc, 32'h3000);
        checkVal("mid_drain_rst_req", 32'(if_req), 32'h0);

        // Wrap-around of the sequential PC.
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
        checkVal("pre_wrap", pc, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkVal("wrap", pc, 32'h0000_0000);

        // Randomized traffic checked cycle by cycle.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(63) == 0),
                          ($urandom_range(99) < 20),
                          ($urandom_range(99) < 10),
                          $urandom(),
                          ($urandom_range(99) < 15),
                          $urandom(),
                          ($urandom_range(99) < 70));
        end

        // Saturate the redirect counter.
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
            applyStimulus(0, 0, 0, 0, 1, $urandom(), 1, (i % 4096) == 0);
        end
        checkOutput();
        checkVal("saturate", 32'(redirect_cnt), 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the fetch-stage program counter of the five-stage pipeline and sequences its updates. Each cycle it chooses the next PC from three sources: sequential PC+4, the taken-branch target resolved in EX, and the jump/JR target produced in ID. It drives a hold-until-ack request to instruction memory and issues the IF/ID and ID/EX flushes on every redirect. It sits between the next-PC target adders, the hazard unit and the instruction memory port.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- CNT_W, 16, width of the saturating redirect counter

- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  load-use hazard from hazard unit; holds PC and suppresses jump redirect
- br_taken  in  1  EX-stage branch resolved taken
- br_target  in  32  branch target (pc + sign-extended offset<<2)
- jmp  in  1  ID-stage J/JAL/JR decoded
- jmp_target  in  32  jump target ({pc[31:28],addr,00} or register for JR)
- if_ack  in  1  imem returns instruction for if_addr this cycle
- if_req  out  1  fetch request valid
- if_addr  out  32  fetch address; stable while if_req=1 and if_ack=0
- pc  out  32  current PC register
- pc_plus4  out  32  pc + 4, modulo 2^32
- if_valid  out  1  fetched instruction is written into IF/ID this cycle
- flush_ifid  out  1  squash IF/ID this cycle
- flush_idex  out  1  squash ID/EX this cycle
- redirect_cnt  out  CNT_W  accepted redirects, saturating

## Operation
- States: BOOT, FETCH, DRAIN. Reset enters BOOT. BOOT lasts 1 cycle, then FETCH. BOOT ignores every input.
- Effective redirect: br_taken has priority, target = br_target. Otherwise jmp & !stall, target = jmp_target. jmp is ignored whenever br_taken=1, stall=1 or state=DRAIN.
- The target is loaded with bits [1:0] forced to 00.
- flush_ifid = effective redirect (any source). flush_idex = br_taken only. Both are combinational and forced to 0 in BOOT and during rst.
- FETCH: if_req=1, if_addr=pc. The first matching case applies:
  - Redirect & if_ack: pc<=target, stay in FETCH, if_valid=0.
  - Redirect & !if_ack: pend<=target, go to DRAIN. pc is unchanged so if_addr stays stable.
  - if_ack & stall: pc is held, if_valid=0. The returned word is discarded and the same pc is refetched.
  - if_ack & !stall: pc<=pc+4, if_valid=1.
  - No if_ack: hold.
- DRAIN: if_req=1, if_addr=old pc, if_valid=0. br_taken overwrites pend and asserts both flushes. On if_ack: pc<=pend (or the same-cycle br_target), go to FETCH.
- redirect_cnt increments by 1 per accepted redirect, including a br_taken overwrite in DRAIN. It saturates at all-ones.
- pc+4 wraps from 32'hFFFF_FFFC to 32'h0000_0000.

## Timing
- Reset values: pc=RESET_PC, pc_plus4=RESET_PC+4, if_req=0, if_valid=0, flush_ifid=0, flush_idex=0, redirect_cnt=0, state=BOOT, pend=0.
- rst=1 in any state (including DRAIN with a request outstanding) returns to BOOT next edge. Any in-flight ack is ignored.
- First fetch: if_req rises 1 cycle after rst deasserts.
- Zero-wait memory (if_ack tied high): 1 instruction per cycle. A redirect asserted in cycle N fetches the target in cycle N+1.
- Wait-state memory: a redirect without ack costs the remaining wait cycles plus 1.
- All state updates happen on the rising edge of clk.
- if_valid and the flushes are combinational within the cycle they describe.

## Test plan
- Reset with RESET_PC=32'h3000 and if_ack=1 → BOOT 1 cycle, then if_addr 3000, 3004, 3008 on consecutive cycles with if_valid=1 each.
- At pc=3008: stall=1 for 2 cycles with ack → pc held at 3008, if_valid=0, then 300C after stall drops. jmp=1 during stall is ignored and flush_ifid=0.
- At pc=3010: br_taken=1 with br_target=3100 and jmp=1 with jmp_target=3200 in the same cycle → flush_ifid=flush_idex=1, next if_addr=3100, redirect_cnt+1.
- Memory with 3 wait states, jmp to 4000 in the first wait cycle → if_addr stays at old pc until ack, if_valid=0 on that ack, then if_addr=4000.
- In DRAIN with pend=4000: br_taken to 5002 → pend=5000 and both flushes asserted. After ack, fetch 5000. Also assert rst mid-DRAIN → BOOT and pc=RESET_PC.
- Run pc to FFFF_FFFC → next pc 0000_0000. Force 2^CNT_W+5 redirects → redirect_cnt holds at all-ones.
